i2s_transmitter: RTL
====================

# i2s_transmitter

- Serializes stereo PCM samples onto an I2S bus toward an external DAC or amplifier.
- Acts as bus controller: generates sck and ws from clk_in and drives sd.
- Complements the microphone capture path. Upstream DSP writes one stereo frame per transfer over an AXI-stream-style valid/ready interface.
- Holds one pending frame while the previous one shifts out, and pads to silence on underrun.

## Interface
- CLK_DIV, 8, sck half-period in clk_in cycles (≥2); sck = clk_in/(2·CLK_DIV)
- SAMPLE_WIDTH, 24, bits per channel sample (≤ SLOT_WIDTH)
- SLOT_WIDTH, 32, sck periods per channel slot; frame = 2·SLOT_WIDTH sck periods
- clk_in  input  1  sole clock
- rst_in  input  1  reset, synchronous, active-high
- s_axis_tvalid  input  1  frame valid
- s_axis_tready  output  1  frame accepted when tvalid&&tready
- s_axis_tdata  input  2·SAMPLE_WIDTH  {left, right}, two's complement
- sck  output  1  I2S serial clock
- ws  output  1  word select: 0 = left, 1 = right
- sd  output  1  serial data, MSB first
- frame_start  output  1  one-cycle pulse when a frame begins (bit 0 driven)
- underrun  output  1  one-cycle pulse when a frame begins with no pending data

## Operation
- Divider div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0 and sck toggles.
- A fall strobe is the cycle in which sck is registered 1→0. All sd/ws updates happen only on fall strobes. The receiver samples on sck rising edges.
- Bit counter b counts 0..2·SLOT_WIDTH-1 and advances (wrapping) on each fall strobe.
- Left slot is b = 0..SLOT_WIDTH-1; right slot is b = SLOT_WIDTH..2·SLOT_WIDTH-1.
- ws = 1 iff SLOT_WIDTH-1 ≤ b ≤ 2·SLOT_WIDTH-2. This gives the standard I2S one-bit lead: ws changes one sck before each slot MSB.
- sd at bit position k in a slot is sample[SAMPLE_WIDTH-1-k] for k < SAMPLE_WIDTH, else 0.
- Hold register: one frame plus hold_valid.
  - s_axis_tready = !hold_valid && !rst_in.
  - On handshake, hold captures tdata and hold_valid←1.
- Load, on a fall strobe where b wraps to 0:
  - If hold_valid: the shift registers take hold, hold_valid←0, and frame_start pulses.
  - Else: the shift registers take zeros, and frame_start and underrun both pulse in the same cycle.
- A frame is never truncated or replaced mid-frame.
- Simultaneous events: acceptance cannot coincide with a load, because tready is low while hold_valid is set. After a load, tready rises on the following cycle.

## Timing
- Reset values (cycle after rst_in sampled high): sck=0, ws=0, sd=0, div_cnt=0, b=2·SLOT_WIDTH-1, hold_valid=0, frame_start=0, underrun=0. s_axis_tready is 0 while rst_in is high and 1 the first cycle after.
- After reset release:
  - First sck rise: CLK_DIV cycles later.
  - First fall strobe (frame 0 load): 2·CLK_DIV cycles later.
- A frame accepted before the first fall strobe plays in frame 0; otherwise frame 0 underruns.
- Frame period: 4·SLOT_WIDTH·CLK_DIV clk_in cycles (1024 with defaults).
- Latency: a frame accepted at cycle t drives its left MSB at the next frame boundary after t, at most one frame period plus one cycle later.
- sd and ws are stable for a full sck period around each rising edge.
- Reset mid-frame:
  - The in-flight frame is aborted and any pending frame is discarded.
  - Outputs take reset values on the next cycle.
  - No partial bits resume afterward.
- Outputs are registered; none is combinational from inputs except s_axis_tready.

## Test plan
- Reset, then hold tvalid with {24'hA5A5A5, 24'h123456} → frame_start at cycle 16 after release. Bits sampled on sck rises:
  - ws=0: A5A5A5 then 8 zeros.
  - ws=1: 123456 then 8 zeros.
  - ws rises at b=31 and falls at b=63.
- No tvalid after reset → underrun and frame_start pulse together every 1024 cycles; sd stays 0; ws still toggles.
- Back-to-back streaming: source always valid with incrementing samples → exactly one handshake per frame, each landing within a cycle after frame_start. No dropped or duplicated frames over 8 frames; underrun never asserts.
- Backpressure: tvalid high while hold_valid=1 → tready stays 0 and tdata changes are ignored until the next load. The captured (first) frame is transmitted.
- Assert rst_in for one cycle at b=40 → the next cycle shows sck=ws=sd=0 and a cleared pending frame. The next frame_start comes 16 cycles after release.
- Parameter sweep with CLK_DIV=2, SAMPLE_WIDTH=16, SLOT_WIDTH=16 → sck period is 4 cycles, frame is 128 cycles, and no zero padding occurs.

Source files
------------

// File: rtl/i2s_transmitter_if.sv
// Stereo frame stream into the I2S transmitter: one {left, right} PCM frame per
// valid/ready handshake.
interface i2s_transmitter_if #(
  parameter int unsigned SAMPLE_WIDTH = 24
) ();

  logic                        tvalid;
  logic                        tready;
  logic [2*SAMPLE_WIDTH-1:0]   tdata;

  modport master (
    output tvalid,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    output tready
  );

endinterface

// File: rtl/i2s_transmitter.sv
// I2S bus controller: divides clk_in down to sck, drives ws/sd with the standard
// one-bit lead, buffers one pending stereo frame and sends silence on underrun.
module i2s_transmitter #(
  parameter int unsigned CLK_DIV      = 8,
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned SLOT_WIDTH   = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  i2s_transmitter_if.slave  s_axis,
  output logic              sck,
  output logic              ws,
  output logic              sd,
  output logic              frame_start,
  output logic              underrun
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int unsigned DIV_W      = $clog2(CLK_DIV);
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] WS_FIRST = BIT_W'(SLOT_WIDTH - 1);
  localparam logic [BIT_W-1:0] WS_LAST  = BIT_W'(FRAME_BITS - 2);

  typedef enum logic {
    HOLD_EMPTY,
    HOLD_FULL
  } hold_state_t;

  hold_state_t               hold_state_q, hold_state_d;
  logic [2*SAMPLE_WIDTH-1:0] hold_data_q;

  logic [DIV_W-1:0]          div_cnt_q;
  logic [BIT_W-1:0]          bit_q;
  logic [BIT_W-1:0]          bit_next;
  logic [FRAME_BITS-1:0]     shift_q;
  logic [FRAME_BITS-1:0]     frame_padded;
  logic                      sck_q;
  logic                      ws_q;
  logic                      frame_start_q;
  logic                      underrun_q;

  logic                      div_wrap;
  logic                      fall_strobe;
  logic                      frame_load;
  logic                      accept;

  assign div_wrap    = (div_cnt_q == DIV_LAST);
  assign fall_strobe = div_wrap && sck_q;
  assign frame_load  = fall_strobe && (bit_q == BIT_LAST);
  assign bit_next    = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;

  assign s_axis.tready = (hold_state_q == HOLD_EMPTY) && !rst_in;
  assign accept        = s_axis.tvalid && s_axis.tready;

  // Hold slot: filled by a handshake, emptied only by a frame-boundary load.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hold_state_q <= HOLD_EMPTY;
      hold_data_q  <= '0;
    end else begin
      hold_state_q <= hold_state_d;
      if (accept) begin
        hold_data_q <= s_axis.tdata;
      end
    end
  end

  always_comb begin
    hold_state_d = hold_state_q;
    unique case (hold_state_q)
      HOLD_EMPTY: if (accept)     hold_state_d = HOLD_FULL;
      HOLD_FULL:  if (frame_load) hold_state_d = HOLD_EMPTY;
      default:                    hold_state_d = HOLD_EMPTY;
    endcase
  end

  // Each slot is MSB-justified and zero-padded; an empty hold yields silence.
  always_comb begin
    frame_padded = '0;
    if (hold_state_q == HOLD_FULL) begin
      frame_padded[FRAME_BITS-1 -: SAMPLE_WIDTH] = hold_data_q[2*SAMPLE_WIDTH-1 -: SAMPLE_WIDTH];
      frame_padded[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = hold_data_q[SAMPLE_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_cnt_q     <= '0;
      sck_q         <= 1'b0;
      bit_q         <= BIT_LAST;
      ws_q          <= 1'b0;
      shift_q       <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      div_cnt_q     <= div_wrap ? '0 : div_cnt_q + 1'b1;
      if (div_wrap) begin
        sck_q <= !sck_q;
      end
      // sd is the shifter MSB, so it and ws only ever move on sck falls.
      if (fall_strobe) begin
        bit_q <= bit_next;
        ws_q  <= (bit_next >= WS_FIRST) && (bit_next <= WS_LAST);
        if (frame_load) begin
          shift_q       <= frame_padded;
          frame_start_q <= 1'b1;
          underrun_q    <= (hold_state_q == HOLD_EMPTY);
        end else begin
          shift_q <= shift_q << 1;
        end
      end
    end
  end

  assign sck         = sck_q;
  assign ws          = ws_q;
  assign sd          = shift_q[FRAME_BITS-1];
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule
